// File: rtl/int_fp_pkg.sv
// rtl/int_fp_pkg.sv - shared constants and types for the int8/fp16 divider
// Purpose: fp16 field widths, exponent bias, iteration counts and FSM state
//          encoding shared by the divider top and its datapath helper.
// Ports:   none (package).
package int_fp_pkg;

  localparam int FP_EXP_W  = 5;
  localparam int FP_FRAC_W = 10;
  localparam int FP_BIAS   = 15;

  localparam int INT_ITER  = 8;
  localparam int FP_ITER   = 12;

  // Magnitude bits of +/-infinity (exponent all ones, zero fraction).
  localparam logic [14:0] FP_INF_MAG = 15'h7C00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one restoring-division iteration (combinational)
// Purpose: shift the partial remainder left, bring in one numerator bit,
//          subtract the divisor when it fits and report the quotient bit.
// Ports:   i_rem     - current 13-bit partial remainder
//          i_divisor - 12-bit divisor
//          i_bit     - next numerator bit (MSB first)
//          o_rem     - next 13-bit partial remainder
//          o_q       - quotient bit produced by this iteration
module div_restoring_step (
  input  logic [12:0] i_rem,
  input  logic [11:0] i_divisor,
  input  logic        i_bit,
  output logic [12:0] o_rem,
  output logic        o_q
);

  logic [13:0] w_shift;
  logic [13:0] w_divisor;

  assign w_shift   = {i_rem, i_bit};
  assign w_divisor = {2'b00, i_divisor};

  assign o_q   = (w_shift >= w_divisor);
  // The remainder stays below the divisor, so 13 bits always hold the result.
  assign o_rem = o_q ? 13'(w_shift - w_divisor) : w_shift[12:0];

endmodule

// File: rtl/int_fp_div.sv
// rtl/int_fp_div.sv - iterative int8 / fp16 divider with valid/ready handshake
// Purpose: restoring divider, one quotient bit per cycle; mode=1 divides fp16
//          values, mode=0 divides signed int8 values carried in bits [7:0].
// Ports:   clk, rst               - clock and synchronous active-high reset
//          in_valid / in_ready    - operand handshake (ready only in IDLE)
//          mode                   - 1 = fp16, 0 = int8
//          a, b                   - dividend, divisor
//          out_valid / out_ready  - result handshake
//          c, error               - quotient and error flag
module int_fp_div
  import int_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        error
);

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_c;
  logic        r_error;

  logic        r_mode;
  logic        r_sign;
  logic        r_a_zero;
  logic        r_b_zero;
  logic [4:0]  r_ea;
  logic [4:0]  r_eb;
  logic [12:0] r_rem;
  logic [11:0] r_num;
  logic [11:0] r_div;
  logic [11:0] r_quo;
  logic [3:0]  r_cnt;

  // ---------------- operand preprocessing ----------------
  logic [7:0]  w_a_mag;
  logic [7:0]  w_b_mag;
  logic [12:0] w_rem_init;
  logic [11:0] w_num_init;
  logic [11:0] w_div_init;
  logic        w_sign_init;
  logic        w_b_zero_init;

  assign w_a_mag = a[7] ? (~a[7:0] + 8'd1) : a[7:0];
  assign w_b_mag = b[7] ? (~b[7:0] + 8'd1) : b[7:0];

  always_comb begin
    w_rem_init    = 13'd0;
    w_num_init    = 12'd0;
    w_div_init    = 12'd0;
    w_sign_init   = 1'b0;
    w_b_zero_init = 1'b0;
    if (mode) begin
      // Numerator is {1,a[9:0]} << 11. Its top 10 bits are preloaded as the
      // remainder (always below mb, which is >= 2^10), leaving 12 bits to
      // shift in: a[0] followed by eleven zeros.
      w_rem_init    = {3'b000, 1'b1, a[9:1]};
      w_num_init    = {a[0], 11'd0};
      w_div_init    = {1'b0, 1'b1, b[9:0]};
      w_sign_init   = a[15] ^ b[15];
      w_b_zero_init = (b[14:0] == 15'd0);
    end else begin
      w_num_init    = {w_a_mag, 4'd0};
      w_div_init    = {4'd0, w_b_mag};
      w_sign_init   = a[7] ^ b[7];
      w_b_zero_init = (b[7:0] == 8'd0);
    end
  end

  // ---------------- iteration datapath ----------------
  logic [12:0] w_rem_next;
  logic        w_q_bit;

  div_restoring_step u_step (
    .i_rem     (r_rem),
    .i_divisor (r_div),
    .i_bit     (r_num[11]),
    .o_rem     (w_rem_next),
    .o_q       (w_q_bit)
  );

  // ---------------- result post-processing ----------------
  logic signed [6:0] w_exp;
  logic [9:0]        w_frac;
  logic [15:0]       w_int_q;
  logic [15:0]       w_c_res;
  logic              w_err_res;

  // Quotient lies in [2^10, 2^12); a clear top bit costs one exponent step.
  assign w_exp   = 7'({2'b00, r_ea}) - 7'({2'b00, r_eb}) + 7'(FP_BIAS)
                   - {6'd0, ~r_quo[11]};
  assign w_frac  = r_quo[11] ? r_quo[10:1] : r_quo[9:0];
  assign w_int_q = {8'd0, r_quo[7:0]};

  always_comb begin
    w_c_res   = 16'd0;
    w_err_res = 1'b0;
    if (r_mode) begin
      if (r_b_zero) begin
        w_c_res   = {r_sign, FP_INF_MAG};
        w_err_res = 1'b1;
      end else if (r_a_zero) begin
        w_c_res   = {r_sign, 15'd0};
      end else if (w_exp >= 7'sd31) begin
        w_c_res   = {r_sign, FP_INF_MAG};
        w_err_res = 1'b1;
      end else if (w_exp <= 7'sd0) begin
        w_c_res   = {r_sign, 15'd0};
        w_err_res = 1'b1;
      end else begin
        w_c_res   = {r_sign, w_exp[FP_EXP_W-1:0], w_frac};
      end
    end else begin
      if (r_b_zero) begin
        w_err_res = 1'b1;
      end else begin
        w_c_res   = r_sign ? (16'd0 - w_int_q) : w_int_q;
      end
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_c         <= 16'd0;
      r_error     <= 1'b0;
      r_mode      <= 1'b0;
      r_sign      <= 1'b0;
      r_a_zero    <= 1'b0;
      r_b_zero    <= 1'b0;
      r_ea        <= 5'd0;
      r_eb        <= 5'd0;
      r_rem       <= 13'd0;
      r_num       <= 12'd0;
      r_div       <= 12'd0;
      r_quo       <= 12'd0;
      r_cnt       <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode     <= mode;
            r_sign     <= w_sign_init;
            r_a_zero   <= (a[14:0] == 15'd0);
            r_b_zero   <= w_b_zero_init;
            r_ea       <= a[14:10];
            r_eb       <= b[14:10];
            r_rem      <= w_rem_init;
            r_num      <= w_num_init;
            r_div      <= w_div_init;
            r_quo      <= 12'd0;
            r_cnt      <= mode ? 4'(FP_ITER) : 4'(INT_ITER);
            r_in_ready <= 1'b0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_num <= {r_num[10:0], 1'b0};
          r_quo <= {r_quo[10:0], w_q_bit};
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= NORM;
          end
        end
        NORM: begin
          r_c     <= w_c_res;
          r_error <= w_err_res;
          r_state <= DONE;
        end
        DONE: begin
          // c/error settle on entry; out_valid follows one cycle later so
          // latency is N+2 edges regardless of operand values.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign error     = r_error;

endmodule

// File: tb/tb_int_fp_div.sv
// tb/tb_int_fp_div.sv - directed and randomised self-checking bench for int_fp_div
module tb_int_fp_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        error;

  int n_tests;
  int n_fail;

  int_fp_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents operands, waits for acceptance, then counts
  // edges after the accepting edge until out_valid is seen.
  task automatic op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                    output logic [15:0] cv, output logic ev, output int lat);
    int guard;
    mode     = m;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    cv = c;
    ev = error;
  endtask

  function automatic void model(input logic m, input logic [15:0] av, input logic [15:0] bv,
                                output logic [15:0] cv, output logic ev);
    int ai, bi, qi, ma, mb, ea, eb, e, frac;
    logic s;
    cv = 16'h0000;
    ev = 1'b0;
    if (!m) begin
      ai = int'($signed(av[7:0]));
      bi = int'($signed(bv[7:0]));
      if (bi == 0) begin
        ev = 1'b1;
      end else begin
        qi = ai / bi;
        cv = qi[15:0];
      end
    end else begin
      s  = av[15] ^ bv[15];
      ea = int'(av[14:10]);
      eb = int'(bv[14:10]);
      ma = 1024 + int'(av[9:0]);
      mb = 1024 + int'(bv[9:0]);
      qi = (ma * 2048) / mb;
      if (qi >= 2048) begin
        frac = (qi / 2) % 1024;
        e    = ea - eb + 15;
      end else begin
        frac = qi % 1024;
        e    = ea - eb + 14;
      end
      if (bv[14:0] == 15'd0) begin
        cv = {s, 15'h7C00};
        ev = 1'b1;
      end else if (av[14:0] == 15'd0) begin
        cv = {s, 15'h0000};
      end else if (e >= 31) begin
        cv = {s, 15'h7C00};
        ev = 1'b1;
      end else if (e <= 0) begin
        cv = {s, 15'h0000};
        ev = 1'b1;
      end else begin
        cv = {s, e[4:0], frac[9:0]};
      end
    end
  endfunction

  initial begin
    logic [15:0] rc;
    logic        re;
    int          lat;
    logic [15:0] ra, rb, ec;
    logic        rm, ee;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset in_ready", {15'd0, in_ready}, 16'd1);
    chk("reset out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset c", c, 16'h0000);
    chk("reset error", {15'd0, error}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // fp basic
    op(1'b1, 16'h4600, 16'h4000, rc, re, lat);
    chk("fp 6/2 c", rc, 16'h4200);
    chk("fp 6/2 err", {15'd0, re}, 16'd0);
    chk("fp latency", 16'(lat), 16'd14);
    op(1'b1, 16'h3C00, 16'h4200, rc, re, lat);
    chk("fp 1/3 c", rc, 16'h3555);
    chk("fp 1/3 err", {15'd0, re}, 16'd0);

    // int
    op(1'b0, 16'h00F9, 16'h0002, rc, re, lat);
    chk("int -7/2 c", rc, 16'hFFFD);
    chk("int -7/2 err", {15'd0, re}, 16'd0);
    chk("int latency", 16'(lat), 16'd10);
    op(1'b0, 16'h0080, 16'h00FF, rc, re, lat);
    chk("int -128/-1 c", rc, 16'h0080);
    chk("int -128/-1 err", {15'd0, re}, 16'd0);
    op(1'b0, 16'h0005, 16'h0000, rc, re, lat);
    chk("int div0 c", rc, 16'h0000);
    chk("int div0 err", {15'd0, re}, 16'd1);

    // fp specials
    op(1'b1, 16'h3C00, 16'h0000, rc, re, lat);
    chk("fp div0 c", rc, 16'h7C00);
    chk("fp div0 err", {15'd0, re}, 16'd1);
    op(1'b1, 16'h8000, 16'h3C00, rc, re, lat);
    chk("fp zero c", rc, 16'h8000);
    chk("fp zero err", {15'd0, re}, 16'd0);
    op(1'b1, 16'h7800, 16'h0400, rc, re, lat);
    chk("fp ovf c", rc, 16'h7C00);
    chk("fp ovf err", {15'd0, re}, 16'd1);
    op(1'b1, 16'h0400, 16'h7800, rc, re, lat);
    chk("fp unf c", rc, 16'h0000);
    chk("fp unf err", {15'd0, re}, 16'd1);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    op(1'b1, 16'h4600, 16'h4000, rc, re, lat);
    chk("bp first c", rc, 16'h4200);
    mode     = 1'b0;
    a        = 16'h0009;
    b        = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp hold c", c, 16'h4200);
      chk("bp hold error", {15'd0, error}, 16'd0);
      chk("bp hold in_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp release out_valid", {15'd0, out_valid}, 16'd0);
    chk("bp release in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    chk("bp no stray accept", {15'd0, in_ready}, 16'd1);

    // reset mid-DIV
    mode     = 1'b1;
    a        = 16'h3C00;
    b        = 16'h4200;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid-div busy", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort in_ready", {15'd0, in_ready}, 16'd1);
    chk("abort out_valid", {15'd0, out_valid}, 16'd0);
    chk("abort c", c, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    op(1'b1, 16'h4600, 16'h4000, rc, re, lat);
    chk("post-abort c", rc, 16'h4200);
    chk("post-abort latency", 16'(lat), 16'd14);

    // back-to-back random, in_valid held high
    for (int i = 0; i < 1000; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        if (rm) rb[14:0] = 15'd0;
        else    rb[7:0]  = 8'd0;
      end
      if ($urandom_range(0, 31) == 0) ra[14:0] = 15'd0;
      model(rm, ra, rb, ec, ee);
      op(rm, ra, rb, rc, re, lat);
      chk($sformatf("rnd%0d c m%0d %h/%h", i, rm, ra, rb), rc, ec);
      chk($sformatf("rnd%0d err", i), {15'd0, re}, {15'd0, ee});
      chk($sformatf("rnd%0d latency", i), 16'(lat), rm ? 16'd14 : 16'd10);
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_fp_div.md
Name: int_fp_div

Overview:
- Iterative divider, the inverse operator to the team's int/fp16 multiplier.
- Shares its operand formats and mode select:
  - mode=1: IEEE-style fp16 (1 sign, 5 exponent bits, bias 15, 10 fraction bits).
  - mode=0: signed 8-bit two's-complement integer, carried in bits [7:0].
- Sits beside the multiplier in the MAC datapath.
- Uses a valid/ready handshake on both sides and restoring division, one quotient bit per cycle.

Parameters:
- FP_BIAS, 15, fp16 exponent bias.
- INT_ITER, 8, quotient iterations in int mode.
- FP_ITER, 12, quotient iterations in fp mode.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b and mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- mode  in  1  1 = fp16, 0 = int8.
- a  in  16  dividend.
- b  in  16  divisor.
- out_valid  out  1  c and error are valid.
- out_ready  in  1  consumer accepts the result.
- c  out  16  quotient.
- error  out  1  divide-by-zero, overflow or underflow (fp); divide-by-zero (int).

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, c=0, error=0, all internal registers cleared.
- Reset mid-operation aborts the operation; any pending result is discarded.
- States: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE:
  - On in_valid&&in_ready, register mode and the preprocessed operands, go to DIV, load counter = (mode ? FP_ITER : INT_ITER).
  - Inputs are ignored in every other state.
- DIV:
  - Each cycle: shift the remainder left by 1 and bring in the next numerator bit.
  - If remainder >= divisor, subtract and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; at counter==1, go to NORM.
- NORM:
  - Apply sign, exponent and specials; register c and error.
  - Go to DONE.
- DONE:
  - out_valid=1; c and error held stable while out_ready=0.
  - On out_ready, go to IDLE and drop out_valid the same edge.
  - The next operand is accepted at the earliest one cycle later; there is no bypass.
- Latency is fixed and independent of operand values: out_valid rises N+2 edges after the accepting edge (int 10, fp 14).
- Int mode:
  - Divide magnitudes |a[7:0]| by |b[7:0]|, 8 bits each (128 representable).
  - Quotient truncates toward zero; sign = a[7]^b[7].
  - c is the 16-bit two's-complement result, so -128/-1 = 0x0080.
  - b[7:0]==0: c=0x0000, error=1. error is otherwise 0.
- Fp mode, significands and quotient:
  - ma = {1,a[9:0]}, mb = {1,b[9:0]}.
  - Numerator = ma<<11 (22 bits); 12-bit quotient q = floor(numerator/mb), so q is in [2^10, 2^12).
- Fp mode, normalisation (e is a signed 7-bit value):
  - If q[11]=1: frac = q[10:1], e = ea-eb+FP_BIAS.
  - Else: frac = q[9:0], e = ea-eb+FP_BIAS-1.
  - Rounding is truncation.
- Fp mode, sign and result encoding:
  - sign = a[15]^b[15].
  - b[14:0]==0: c={sign,5'h1F,10'h0}, error=1 (takes priority over a==0).
  - Else a[14:0]==0: c={sign,15'h0}, error=0.
  - Else e>=31: c={sign,5'h1F,10'h0}, error=1.
  - Else e<=0: c={sign,15'h0}, error=1.
  - Else c={sign,e[4:0],frac}, error=0.
- Fp exponent fields 0 and 31 are treated as ordinary numbers (no subnormal/NaN handling), consistent with the multiplier.

Decomposition:
- Shared package (int_fp_pkg):
  - fp16 field widths and FP_BIAS.
  - FP_INF_MAG = 15'h7C00.
  - State enum {IDLE, DIV, NORM, DONE}.
  - INT_ITER and FP_ITER constants.
- One sub-module, div_restoring_step: combinational single-iteration compare/subtract/shift, 12-bit divisor, 13-bit remainder; outputs next remainder and quotient bit.
- The top level holds the FSM, counter, pre/post-processing and output registers.

Test Plan:
- fp a=0x4600 (6.0), b=0x4000 (2.0), out_ready=1 -> c=0x4200, error=0, out_valid exactly 14 cycles after accept; a=0x3C00, b=0x4200 -> c=0x3555.
- int a=0x00F9 (-7), b=0x0002 -> c=0xFFFD at cycle 10; a=0x0080, b=0x00FF -> c=0x0080; a=0x0005, b=0x0000 -> c=0x0000, error=1.
- fp specials:
  - 0x3C00/0x0000 -> 0x7C00, err=1.
  - 0x8000/0x3C00 -> 0x8000, err=0.
  - 0x7800/0x0400 -> 0x7C00, err=1 (overflow).
  - 0x0400/0x7800 -> 0x0000, err=1 (underflow).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c/error stable, in_ready=0, a new in_valid is ignored; release -> out_valid drops next edge, in_ready=1.
- Reset mid-DIV (cycle 4 of fp op) -> next edge in_ready=1, out_valid=0, c=0; a following op 0x4600/0x4000 returns 0x4200 with normal latency.
- Back-to-back: random 1000 int/fp pairs with in_valid held high, checked against a reference model using the truncation rules above.
